// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and control encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Per-cycle pipeline register controls, MSB first as packed below.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Bubble/hold encodings shared with the pipeline register banks.
    localparam hz_ctrl_t CTRL_RESET    = 8'b00000_111;
    localparam hz_ctrl_t CTRL_FREEZE   = 8'b00001_001;
    localparam hz_ctrl_t CTRL_BRANCH   = 8'b11111_110;
    localparam hz_ctrl_t CTRL_LOAD_USE = 8'b00111_010;
    localparam hz_ctrl_t CTRL_RUN      = 8'b11111_000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the five-stage pipeline
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    // Timer holds the number of frozen cycles of the current access,
    // so it must be able to represent MEM_TIMEOUT itself.
    localparam int TMR_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] wait_q, wait_d;
    logic             mem_err_q, mem_err_d;

    logic     load_use;
    logic     timeout_hit;
    logic     mem_done;
    logic     freeze;
    logic     branch_flush;
    hz_ctrl_t ctrl;

    assign load_use = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // The entry cycle is the first frozen cycle, so the timer reads 1 in the
    // first MEM_WAIT cycle; a release is forced after MEM_TIMEOUT frozen cycles.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (state_q == MEM_WAIT) &&
                         (wait_q == TMR_LIMIT);
    assign mem_done    = mem_ready || timeout_hit;
    assign freeze      = (state_q == RUN) ? (mem_req && !mem_ready) : !mem_done;

    // Zero-latency control decode: reset > memory freeze > branch > load-use.
    always_comb begin
        ctrl         = CTRL_RUN;
        branch_flush = 1'b0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (ex_branch_taken) begin
            ctrl         = CTRL_BRANCH;
            branch_flush = 1'b1;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    // Next state for the memory-wait sequencer, wait timer and error flag.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        mem_err_d = mem_err_q;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = TMR_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_done) begin
                    state_d = RUN;
                    wait_d  = '0;
                    if (timeout_hit && !mem_ready) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wait_d  = '0;
            end
        endcase
    end

    // Sequencer registers; reset abandons any wait in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk),
        .clr_i (reset),
        .inc_i (!ctrl.pc_en),
        .cnt_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk),
        .clr_i (reset),
        .inc_i (branch_flush),
        .cnt_o (flush_cnt)
    );

    assign pc_en         = ctrl.pc_en;
    assign if_id_en      = ctrl.if_id_en;
    assign id_ex_en      = ctrl.id_ex_en;
    assign ex_mem_en     = ctrl.ex_mem_en;
    assign mem_wb_en     = ctrl.mem_wb_en;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_err       = mem_err_q;

endmodule
